// File: rtl/rv_arb_pkg.sv
// Shared types and sizing helpers for the round-robin upstream arbiter.
package rv_arb_pkg;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rv_rr_pick.sv
// Rotating priority encoder: first set request at or after ptr_i, wrapping at NUM_REQ.
module rv_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [ID_W-1:0]    winner_o,
  output logic               winner_ok_o
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    winner_o    = '0;
    winner_ok_o = 1'b0;
    sum         = '0;
    idx         = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // Modular index handles non-power-of-2 NUM_REQ without touching unused codes.
      sum = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!winner_ok_o && req_i[idx]) begin
        winner_o    = idx;
        winner_ok_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rv_rr_arbiter.sv
// Burst-locked round-robin arbiter feeding one registered ready/valid stage.
module rv_rr_arbiter
  import rv_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ   = 4,
  parameter  int unsigned WIDTH     = 16,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned ID_W      = id_w(NUM_REQ)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]         ds_data,
  output logic [ID_W-1:0]          ds_id,
  output logic                     ds_valid,
  input  logic                     ds_ready,
  output logic                     locked
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  lock_state_e      state_q, state_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [WIDTH-1:0] ds_data_q, ds_data_d;
  logic [ID_W-1:0]  ds_id_q, ds_id_d;
  logic             ds_valid_q, ds_valid_d;

  logic [WIDTH-1:0] req_arr [NUM_REQ];
  logic [ID_W-1:0]  pick_winner, winner;
  logic             pick_ok, winner_ok;
  logic             can_load, accept;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_arr[i] = req_data[i*WIDTH +: WIDTH];
  end

  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] x);
    return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  rv_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i       (req_valid),
    .ptr_i       (rr_ptr_q),
    .winner_o    (pick_winner),
    .winner_ok_o (pick_ok)
  );

  assign can_load  = !ds_valid_q || ds_ready;
  assign winner    = (state_q == LOCKED) ? owner_q : pick_winner;
  assign winner_ok = (state_q == LOCKED) ? req_valid[owner_q] : pick_ok;
  assign accept    = winner_ok && can_load && !reset;

  // While locked the owner's ready is offered regardless of its own valid.
  always_comb begin
    req_ready = '0;
    if (!reset && can_load) begin
      if (state_q == LOCKED) begin
        req_ready[owner_q] = 1'b1;
      end else if (pick_ok) begin
        req_ready[pick_winner] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      UNLOCKED: begin
        if (accept) begin
          if (MAX_BURST == 1) begin
            rr_ptr_d = inc_id(winner);
          end else begin
            state_d    = LOCKED;
            owner_d    = winner;
            beat_cnt_d = CNT_W'(1);
          end
        end
      end
      LOCKED: begin
        if (!req_valid[owner_q]) begin
          state_d    = UNLOCKED;
          beat_cnt_d = '0;
          rr_ptr_d   = inc_id(owner_q);
        end else if (accept) begin
          if (beat_cnt_q + 1'b1 == CNT_W'(MAX_BURST)) begin
            state_d    = UNLOCKED;
            beat_cnt_d = '0;
            rr_ptr_d   = inc_id(owner_q);
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ds_valid_d = ds_valid_q;
    ds_data_d  = ds_data_q;
    ds_id_d    = ds_id_q;
    if (accept) begin
      ds_valid_d = 1'b1;
      ds_data_d  = req_arr[winner];
      ds_id_d    = winner;
    end else if (ds_ready) begin
      ds_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      ds_valid_q <= 1'b0;
      ds_data_q  <= '0;
      ds_id_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      ds_valid_q <= ds_valid_d;
      ds_data_q  <= ds_data_d;
      ds_id_q    <= ds_id_d;
    end
  end

  assign ds_data  = ds_data_q;
  assign ds_id    = ds_id_q;
  assign ds_valid = ds_valid_q;
  assign locked   = (state_q == LOCKED);

endmodule

// File: tb/tb_rv_rr_arbiter.sv
// Directed and random checks of rv_rr_arbiter against a behavioural turn-taking model.
module tb_rv_rr_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int MB  = 4;
  localparam int IDW = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic           reset;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid, req_ready;
  logic [W-1:0]   ds_data;
  logic [IDW-1:0] ds_id;
  logic           ds_valid, ds_ready, locked;

  logic           reset1;
  logic [N*W-1:0] req_data1;
  logic [N-1:0]   req_valid1, req_ready1;
  logic [W-1:0]   ds_data1;
  logic [IDW-1:0] ds_id1;
  logic           ds_valid1, ds_ready1, locked1;

  rv_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clock(clock), .reset(reset), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .ds_data(ds_data), .ds_id(ds_id), .ds_valid(ds_valid),
    .ds_ready(ds_ready), .locked(locked)
  );

  rv_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(1)) dut1 (
    .clock(clock), .reset(reset1), .req_data(req_data1), .req_valid(req_valid1),
    .req_ready(req_ready1), .ds_data(ds_data1), .ds_id(ds_id1), .ds_valid(ds_valid1),
    .ds_ready(ds_ready1), .locked(locked1)
  );

  int errors = 0;
  int checks = 0;

  // Model: whose turn it is, how many beats the current owner has used, and the output slot.
  bit           m_locked;
  int           m_owner, m_cnt, m_ptr, m_did;
  bit           m_dv;
  logic [W-1:0] m_dd;
  logic [W-1:0] sb [N][$];

  logic [N-1:0] rr_exp_rdy [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
  int           rr_exp_id  [4] = '{3, 1, 3, 1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    if (reset) return -1;
    if (m_dv && !ds_ready) return -1;
    if (m_locked) return req_valid[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic rnd_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
  endtask

  // One clock of the main DUT: check outputs before the edge, then advance the model.
  task automatic cycle();
    int           g;
    logic [N-1:0] g_vec;
    logic [W-1:0] front;
    #1;
    g     = exp_grant();
    g_vec = (g >= 0) ? (N'(1) << g) : '0;
    check("ds_valid", ds_valid, m_dv);
    check("ds_data", ds_data, m_dd);
    check("ds_id", ds_id, m_did);
    check("locked", locked, m_locked);
    if (reset || (m_dv && !ds_ready)) check("req_ready_zero", req_ready, 0);
    else check("grant", req_ready & req_valid, g_vec);
    check("ready_onehot0", $onehot0(req_ready), 1);
    if (!reset && ds_valid && ds_ready) begin
      check("sb_avail", sb[ds_id].size() > 0, 1);
      if (sb[ds_id].size() > 0) begin
        front = sb[ds_id].pop_front();
        check("sb_exit", ds_data, front);
      end
    end
    @(posedge clock);
    if (reset) begin
      m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
      m_dv = 0; m_dd = '0; m_did = 0;
      for (int i = 0; i < N; i++) sb[i].delete();
    end else begin
      if (g >= 0) begin
        m_dv = 1; m_dd = req_data[g*W +: W]; m_did = g;
        sb[g].push_back(m_dd);
      end else if (ds_ready) begin
        m_dv = 0;
      end
      if (m_locked) begin
        if (!req_valid[m_owner]) begin
          m_locked = 0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
        end else if (g >= 0) begin
          m_cnt++;
          if (m_cnt == MB) begin
            m_locked = 0; m_cnt = 0; m_ptr = (m_owner + 1) % N;
          end
        end
      end else if (g >= 0) begin
        if (MB == 1) m_ptr = (g + 1) % N;
        else begin m_locked = 1; m_owner = g; m_cnt = 1; end
      end
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1; req_valid = '1; ds_ready = 1; req_data = '0;
    reset1 = 1; req_valid1 = '0; ds_ready1 = 1;
    req_data1 = {16'h00D3, 16'h00D2, 16'h00D1, 16'h00D0};
    m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_dv = 0; m_dd = '0; m_did = 0;
    @(negedge clock);

    // Reset held with every requester valid
    repeat (3) begin rnd_data(); cycle(); end

    // MAX_BURST=1 instance: seed rr_ptr=3 via one grant to req 2, then reqs 1 and 3 alternate
    reset1 = 0; req_valid1 = 4'b0100;
    #1;
    check("rr1_first", req_ready1, 4'b0100);
    @(negedge clock);
    check("rr1_first_id", ds_id1, 2);
    req_valid1 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr1_ready", req_ready1, rr_exp_rdy[i]);
      check("rr1_locked", locked1, 0);
      @(negedge clock);
      check("rr1_id", ds_id1, rr_exp_id[i]);
      check("rr1_data", ds_data1, 16'h00D0 + 16'(rr_exp_id[i]));
    end
    req_valid1 = '0;

    // All valid, always ready: four-beat bursts rotating 0,1,2,3
    reset = 0; req_valid = '1; ds_ready = 1;
    for (int k = 0; k < 20; k++) begin
      rnd_data(); cycle();
      check("burst_seq_id", ds_id, (k / 4) % 4);
      check("burst_seq_valid", ds_valid, 1);
    end

    // Single beat from req 2, then only req 3: owner gap releases the lock
    reset = 1; cycle(); reset = 0;
    req_valid = 4'b0100; rnd_data(); cycle();
    req_valid = 4'b1000; rnd_data(); cycle();
    check("gap_release", locked, 0);
    rnd_data(); cycle();
    check("gap_next_id", ds_id, 3);
    repeat (3) begin rnd_data(); cycle(); end

    // Downstream stall of five cycles in the middle of a burst
    reset = 1; cycle(); reset = 0;
    req_valid = '1; ds_ready = 1;
    repeat (2) begin rnd_data(); cycle(); end
    ds_ready = 0;
    repeat (5) begin rnd_data(); cycle(); end
    ds_ready = 1;
    repeat (8) begin rnd_data(); cycle(); end

    // Reset in the middle of a burst drops the pending beat
    reset = 1; cycle(); reset = 0;
    repeat (2) begin rnd_data(); cycle(); end
    reset = 1; rnd_data(); cycle();
    check("midreset_valid", ds_valid, 0);
    check("midreset_locked", locked, 0);
    reset = 0; rnd_data(); cycle();
    check("midreset_restart_id", ds_id, 0);

    // Random traffic, backpressure and occasional reset
    for (int k = 0; k < 400; k++) begin
      req_valid = N'($urandom);
      ds_ready  = ($urandom % 4) != 0;
      reset     = ($urandom % 64) == 0;
      rnd_data(); cycle();
    end

    // Drain: every accepted beat must have left exactly once
    reset = 0; req_valid = '0; ds_ready = 1;
    repeat (3) cycle();
    for (int i = 0; i < N; i++) check("sb_drain", sb[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
